// File: rtl/stack_pkg.sv
// Shared constants and encodings for the return-address stack codebase.
package stack_pkg;

    localparam int DEF_WIDTH       = 11;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_PUSH_OFFSET = 1;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10
    } err_code_e;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic store, input logic load);
        return stack_op_e'({store, load});
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module stack_regfile #(
    parameter int WIDTH = stack_pkg::DEF_WIDTH,
    parameter int DEPTH = stack_pkg::DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; entries above level are never observed, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// Return-address stack: level pointer, sticky error flags and push/pop/replace control.
module return_stack
    import stack_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int PUSH_OFFSET = DEF_PUSH_OFFSET,
    parameter int LW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_val,
    input  logic             store,
    input  logic             load,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_val,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    err_code_e        err_ev;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign wdata = in_val - WIDTH'(PUSH_OFFSET);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        level_d = level_q;
        we      = 1'b0;
        waddr   = '0;
        err_ev  = ERR_NONE;
        unique case (decode_op(store, load))
            OP_PUSH: begin
                if (full) begin
                    err_ev = ERR_OVERFLOW;
                end else begin
                    we      = 1'b1;
                    waddr   = AW'(level_q);
                    level_d = level_q + LW'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    err_ev = ERR_UNDERFLOW;
                end else begin
                    level_d = level_q - LW'(1);
                end
            end
            OP_REPLACE: begin
                // On an empty stack a combined request degenerates to a plain push into entry 0.
                we = 1'b1;
                if (empty) begin
                    level_d = LW'(1);
                end else begin
                    waddr = AW'(level_q - LW'(1));
                end
            end
            default: ;
        endcase

        overflow_d  = (overflow_q  & ~clr_err) | (err_ev == ERR_OVERFLOW);
        underflow_d = (underflow_q & ~clr_err) | (err_ev == ERR_UNDERFLOW);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign raddr = empty ? '0 : AW'(level_q - LW'(1));

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .we_i    (we & ~rst),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign out_val   = empty ? '0 : rdata;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
